// File: rtl/uart_pkg.sv
`default_nettype none
// ============================================================================
// Module  : uart_pkg
// Brief   : Shared state encoding and framing constants for the UART transmitter.
// Revision: 1.0
// ============================================================================
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } tx_state_e;

    localparam logic TX_IDLE_LEVEL = 1'b1;
    localparam int   TX_DATA_BITS  = 8;

endpackage
`default_nettype wire

// File: rtl/uart_baud_gen.sv
`default_nettype none
// ============================================================================
// Module  : uart_baud_gen
// Brief   : Bit-period counter; tick_o marks the last clk_i cycle of each bit.
// Revision: 1.0
// ============================================================================
module uart_baud_gen #(
    parameter int CLK_DIV = 16
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic en_i,
    output logic tick_o
);

    localparam int               CNT_W    = $clog2(CLK_DIV);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLK_DIV - 1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // Held at zero while disabled so every frame starts on a fresh bit period.
    always_comb begin
        cnt_d = '0;
        if (en_i && (cnt_q != CNT_LAST)) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign tick_o = en_i && (cnt_q == CNT_LAST);

endmodule
`default_nettype wire

// File: rtl/uart_tx.sv
`default_nettype none
// ============================================================================
// Module  : uart_tx
// Brief   : 8N1 serial transmitter with valid/ready byte intake, LSB first.
//           Define UART_TX_PARITY_EN to insert an even-parity bit before STOP.
// Revision: 1.0
// ============================================================================
module uart_tx
    import uart_pkg::*;
#(
    parameter int CLK_DIV = 16
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic [7:0] data_i,
    input  logic       valid_i,
    output logic       ready_o,
    output logic       tx_o,
    output logic       busy_o
);

    tx_state_e  state_q;
    logic [7:0] shift_q;
    logic [2:0] bit_cnt_q;
    logic       tx_q;
    logic       ready_q;
    logic       tick;
`ifdef UART_TX_PARITY_EN
    logic       parity_q;
`endif

    uart_baud_gen #(
        .CLK_DIV (CLK_DIV)
    ) u_baud_gen (
        .clk_i  (clk_i),
        .rst_i  (rst_i),
        .en_i   (state_q != IDLE),
        .tick_o (tick)
    );

    // tx_q is loaded with the level of the upcoming bit on each bit boundary.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q   <= IDLE;
            shift_q   <= '0;
            bit_cnt_q <= '0;
            tx_q      <= TX_IDLE_LEVEL;
            ready_q   <= 1'b1;
`ifdef UART_TX_PARITY_EN
            parity_q  <= 1'b0;
`endif
        end else begin
            case (state_q)
                IDLE: begin
                    if (valid_i && ready_q) begin
                        shift_q   <= data_i;
                        bit_cnt_q <= '0;
                        tx_q      <= 1'b0;
                        ready_q   <= 1'b0;
                        state_q   <= START;
`ifdef UART_TX_PARITY_EN
                        parity_q  <= ^data_i;
`endif
                    end
                end
                START: begin
                    if (tick) begin
                        tx_q    <= shift_q[0];
                        state_q <= DATA;
                    end
                end
                DATA: begin
                    if (tick) begin
                        shift_q <= shift_q >> 1;
                        if (bit_cnt_q == 3'(TX_DATA_BITS - 1)) begin
                            bit_cnt_q <= '0;
`ifdef UART_TX_PARITY_EN
                            tx_q    <= parity_q;
                            state_q <= PARITY;
`else
                            tx_q    <= TX_IDLE_LEVEL;
                            state_q <= STOP;
`endif
                        end else begin
                            bit_cnt_q <= bit_cnt_q + 3'd1;
                            tx_q      <= shift_q[1];
                        end
                    end
                end
`ifdef UART_TX_PARITY_EN
                PARITY: begin
                    if (tick) begin
                        tx_q    <= TX_IDLE_LEVEL;
                        state_q <= STOP;
                    end
                end
`endif
                STOP: begin
                    if (tick) begin
                        ready_q <= 1'b1;
                        state_q <= IDLE;
                    end
                end
                default: begin
                    tx_q    <= TX_IDLE_LEVEL;
                    ready_q <= 1'b1;
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign tx_o    = tx_q;
    assign ready_o = ready_q;
    assign busy_o  = !ready_q;

endmodule
`default_nettype wire

// File: tb/tb_uart_tx.sv
`default_nettype none
// ============================================================================
// Module  : tb_uart_tx
// Brief   : Self-checking bench for uart_tx at CLK_DIV=4 against a frame model.
// Revision: 1.0
// ============================================================================
module tb_uart_tx;

    localparam int CLK_DIV = 4;
`ifdef UART_TX_PARITY_EN
    localparam int          FRAME_BITS = 11;
    localparam int          EXP_LOW    = 44;
    localparam logic [10:0] F_A5 = 11'h54A;
    localparam logic [10:0] F_01 = 11'h602;
    localparam logic [10:0] F_00 = 11'h400;
    localparam logic [10:0] F_FF = 11'h5FE;
    localparam logic [10:0] F_81 = 11'h502;
    localparam logic [10:0] F_3C = 11'h478;
    localparam logic [10:0] F_5A = 11'h4B4;
`else
    localparam int          FRAME_BITS = 10;
    localparam int          EXP_LOW    = 40;
    localparam logic [10:0] F_A5 = 11'h34A;
    localparam logic [10:0] F_01 = 11'h202;
    localparam logic [10:0] F_00 = 11'h200;
    localparam logic [10:0] F_FF = 11'h3FE;
    localparam logic [10:0] F_81 = 11'h302;
    localparam logic [10:0] F_3C = 11'h278;
    localparam logic [10:0] F_5A = 11'h2B4;
`endif
    localparam int FRAME_CYC = FRAME_BITS * CLK_DIV;

    logic       clk   = 1'b0;
    logic       rst   = 1'b1;
    logic       valid = 1'b0;
    logic [7:0] data  = 8'h00;
    logic       ready;
    logic       tx;
    logic       busy;

    int checks   = 0;
    int failures = 0;

    uart_tx #(
        .CLK_DIV (CLK_DIV)
    ) dut (
        .clk_i   (clk),
        .rst_i   (rst),
        .data_i  (data),
        .valid_i (valid),
        .ready_o (ready),
        .tx_o    (tx),
        .busy_o  (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference: a frame is a list of bit levels, each lasting CLK_DIV cycles.
    function automatic logic exp_bit(input int k, input logic [7:0] d);
        int idx;
        idx = k / CLK_DIV;
        if (idx == 0) return 1'b0;
        if (idx <= 8) return d[idx-1];
`ifdef UART_TX_PARITY_EN
        if (idx == 9) return ^d;
`endif
        return 1'b1;
    endfunction

    logic       m_busy = 1'b0;
    int         m_k    = 0;
    logic [7:0] m_d    = 8'h00;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_busy = 1'b0;
            m_k    = 0;
        end else if (m_busy) begin
            if (m_k == FRAME_CYC - 1) m_busy = 1'b0;
            else m_k++;
        end else if (valid) begin
            m_busy = 1'b1;
            m_k    = 0;
            m_d    = data;
        end
    end

    always @(negedge clk) begin
        chk("tx_model", 32'(tx), 32'(m_busy ? exp_bit(m_k, m_d) : 1'b1));
        chk("ready_model", 32'(ready), 32'(!m_busy));
        chk("busy_model", 32'(busy), 32'(m_busy));
    end

    task automatic wait_ready();
        for (int i = 0; i < 200; i++) begin
            if (ready === 1'b1) return;
            @(negedge clk);
        end
        chk("wait_ready_timeout", 32'd1, 32'd0);
    endtask

    // Leaves the bench at the first negedge after the accept edge (k=0).
    task automatic start(input logic [7:0] d, input logic hold);
        wait_ready();
        valid = 1'b1;
        data  = d;
        @(negedge clk);
        if (!hold) valid = 1'b0;
    endtask

    task automatic capture(output logic [10:0] fr, output int low,
                           input int chg_k, input logic [7:0] chg_d,
                           input logic chg_v, input logic pulse);
        fr  = '0;
        low = 0;
        for (int k = 0; k < 200; k++) begin
            if (k == chg_k) begin
                data  = chg_d;
                valid = chg_v;
            end
            if (pulse && k == chg_k + 1) valid = 1'b0;
            if (ready === 1'b1) return;
            low++;
            if ((k % CLK_DIV) == 1 && (k / CLK_DIV) < 11) fr[k / CLK_DIV] = tx;
            @(negedge clk);
        end
        chk("capture_timeout", 32'd1, 32'd0);
    endtask

    task automatic count_quiet(input int n, output int tx_low, output int rdy_low);
        tx_low  = 0;
        rdy_low = 0;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            if (tx !== 1'b1) tx_low++;
            if (ready !== 1'b1) rdy_low++;
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [10:0] fr;
        int          low;
        int          ql;
        int          qr;

        repeat (2) @(negedge clk);
        chk("reset_tx", 32'(tx), 32'd1);
        chk("reset_ready", 32'(ready), 32'd1);
        chk("reset_busy", 32'(busy), 32'd0);
        #2 rst = 1'b0;
        repeat (2) @(negedge clk);

        start(8'hA5, 1'b0);
        capture(fr, low, -5, 8'h00, 1'b0, 1'b0);
        chk("frame_A5", 32'(fr), 32'(F_A5));
        chk("low_A5", 32'(low), 32'(EXP_LOW));

        start(8'h01, 1'b0);
        capture(fr, low, -5, 8'h00, 1'b0, 1'b0);
        chk("frame_01", 32'(fr), 32'(F_01));

        start(8'h00, 1'b1);
        data = 8'hFF;
        capture(fr, low, -5, 8'h00, 1'b1, 1'b0);
        chk("frame_b2b_00", 32'(fr), 32'(F_00));
        chk("low_b2b_00", 32'(low), 32'(EXP_LOW));
        @(negedge clk);
        valid = 1'b0;
        chk("b2b_second_accept", 32'(ready), 32'd0);
        capture(fr, low, -5, 8'h00, 1'b0, 1'b0);
        chk("frame_b2b_FF", 32'(fr), 32'(F_FF));

        start(8'h81, 1'b0);
        capture(fr, low, 10, 8'h3C, 1'b1, 1'b0);
        chk("frame_81_mid_change", 32'(fr), 32'(F_81));
        @(negedge clk);
        valid = 1'b0;
        chk("accept_3C_after_ready", 32'(ready), 32'd0);
        capture(fr, low, -5, 8'h00, 1'b0, 1'b0);
        chk("frame_3C", 32'(fr), 32'(F_3C));

        start(8'h5A, 1'b0);
        capture(fr, low, 12, 8'hC3, 1'b1, 1'b1);
        chk("frame_5A_pulse", 32'(fr), 32'(F_5A));
        count_quiet(30, ql, qr);
        chk("pulse_no_second_tx", 32'(ql), 32'd0);
        chk("pulse_no_second_busy", 32'(qr), 32'd0);

        start(8'hF0, 1'b0);
        repeat (10) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        chk("midreset_tx", 32'(tx), 32'd1);
        chk("midreset_ready", 32'(ready), 32'd1);
        chk("midreset_busy", 32'(busy), 32'd0);
        @(posedge clk);
        @(negedge clk);
        #2 rst = 1'b0;
        count_quiet(30, ql, qr);
        chk("midreset_no_stray_tx", 32'(ql), 32'd0);
        chk("midreset_idle_ready", 32'(qr), 32'd0);

        for (int i = 0; i < 1500; i++) begin
            @(negedge clk);
            valid = ($urandom_range(0, 2) == 0);
            data  = 8'($urandom);
        end
        @(negedge clk);
        valid = 1'b0;
        repeat (FRAME_CYC + 4) @(negedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
